// File: rtl/planificador_temporizador_pkg.sv
// Shared definitions for the round-robin seconds-timer scheduler:
// state encoding, default clock rate and prescaler width helper.
package temporizador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned CLK_HZ_DEF = 32'd50_000_000;

    // A 1 Hz clock would give a zero-width counter; keep at least one bit.
    function automatic int unsigned presc_w(input int unsigned hz);
        if (hz > 32'd1) begin
            return $clog2(hz);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/planificador_temporizador_if.sv
// Request/grant bundle between the instrumentation control logic (master)
// and the timer scheduler (slave).
interface planificador_temporizador_if #(
    parameter int unsigned N_REQ = 32'd4,
    parameter int unsigned DUR_W = 32'd8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DUR_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [DUR_W-1:0]       remaining;
    logic                   tick;

    modport master (output req, dur, input grant, done, busy, remaining, tick);
    modport slave  (input req, dur, output grant, done, busy, remaining, tick);
endinterface

// File: rtl/planificador_temporizador_divisor_segundos.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while enabled and emits a registered
// one-cycle tick on each wrap; synchronous clear restarts the second.
module divisor_segundos
    import temporizador_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned      CNT_W   = presc_w(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count and tick pulse.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/planificador_temporizador.sv
// Round-robin scheduler sharing one seconds countdown among N_REQ requesters.
// Optional feature: define TIMER_ABORT_EN to let the owner abandon by dropping req.
module planificador_temporizador
    import temporizador_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned N_REQ  = 32'd4,
    parameter int unsigned DUR_W  = 32'd8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    planificador_temporizador_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             found_s;
    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] cand_s;
    logic [DUR_W-1:0] dur_sel_s;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic             tick_s;
    logic             clr_s;
    logic             run_s;

    divisor_segundos #(.CLK_HZ(CLK_HZ)) u_divisor (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (run_s),
        .clr     (clr_s),
        .tick    (tick_s)
    );

    assign run_s     = (state_q == ST_RUN);
    assign ptr_nxt_s = (owner_q == IDX_W'(N_REQ - 32'd1)) ? '0 : owner_q + IDX_W'(1);

    // Round-robin search: first pending request at or above the pointer, with wrap.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand_s = IDX_W'((32'(ptr_q) + 32'(k)) % N_REQ);
            if (!found_s && bus.req[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Duration of the requester being selected.
    always_comb begin
        dur_sel_s = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (sel_s == IDX_W'(i)) begin
                dur_sel_s = bus.dur[i*DUR_W +: DUR_W];
            end else begin
                dur_sel_s = dur_sel_s;
            end
        end
    end

    // Scheduler FSM; DONE holds until the done pulse has been registered once.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        rem_d   = rem_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = N_REQ'(1) << sel_s;
                    owner_d = sel_s;
                    rem_d   = dur_sel_s;
                    clr_s   = 1'b1;
                    state_d = (dur_sel_s == '0) ? ST_DONE : ST_RUN;
                end else begin
                    grant_d = '0;
                    rem_d   = '0;
                end
            end
            ST_RUN: begin
`ifdef TIMER_ABORT_EN
                if ((grant_q & bus.req) == '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                    ptr_d   = ptr_nxt_s;
                end else
`endif
                if (tick_s) begin
                    if (rem_q == DUR_W'(1)) begin
                        state_d = ST_DONE;
                        rem_d   = '0;
                        done_d  = grant_q;
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (done_q != '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_nxt_s;
                end else begin
                    done_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                rem_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Scheduler registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.remaining = rem_q;
    assign bus.tick      = tick_s;

endmodule

// File: tb/tb_planificador_temporizador.sv
// Directed self-checking bench for planificador_temporizador at CLK_HZ=10,
// N_REQ=4, DUR_W=8; the abort scenario follows TIMER_ABORT_EN.
module tb_planificador_temporizador;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    planificador_temporizador_if #(.N_REQ(32'd4), .DUR_W(32'd8)) bus_if ();

    planificador_temporizador #(
        .CLK_HZ (32'd10),
        .N_REQ  (32'd4),
        .DUR_W  (32'd8)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        bus_if.req = 4'b0000;
        bus_if.dur = 32'd0;
        cyc(3);
        chk("rst_grant", 32'(bus_if.grant), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_rem", 32'(bus_if.remaining), 32'd0);
        chk("rst_tick", 32'(bus_if.tick), 32'd0);
        reset_n = 1'b1;
        cyc(1);

        // Single request, requester 1, 3 s; dur change mid-run must be ignored.
        bus_if.dur = {8'd0, 8'd0, 8'd3, 8'd0};
        bus_if.req = 4'b0010;
        cyc(1);
        chk("A_grant0", 32'(bus_if.grant), 32'h2);
        chk("A_rem0", 32'(bus_if.remaining), 32'd3);
        chk("A_busy0", 32'(bus_if.busy), 32'd1);
        for (int t = 1; t <= 33; t++) begin
            cyc(1);
            chk($sformatf("A_tick@%0d", t), 32'(bus_if.tick),
                (t == 10 || t == 20 || t == 30) ? 32'd1 : 32'd0);
            chk($sformatf("A_done@%0d", t), 32'(bus_if.done), (t == 31) ? 32'h2 : 32'h0);
            chk($sformatf("A_rem@%0d", t), 32'(bus_if.remaining),
                (t <= 10) ? 32'd3 : (t <= 20) ? 32'd2 : (t <= 30) ? 32'd1 : 32'd0);
            chk($sformatf("A_grant@%0d", t), 32'(bus_if.grant), (t <= 31) ? 32'h2 : 32'h0);
            chk($sformatf("A_busy@%0d", t), 32'(bus_if.busy), (t <= 31) ? 32'd1 : 32'd0);
            if (t == 5) bus_if.dur[15:8] = 8'd9;
            if (t == 31) bus_if.req = 4'b0000;
        end

        // Zero duration, requester 2.
        bus_if.dur = 32'd0;
        bus_if.req = 4'b0100;
        cyc(1);
        chk("B_grant0", 32'(bus_if.grant), 32'h4);
        chk("B_done0", 32'(bus_if.done), 32'h0);
        cyc(1);
        chk("B_done1", 32'(bus_if.done), 32'h4);
        chk("B_tick1", 32'(bus_if.tick), 32'd0);
        bus_if.req = 4'b0000;
        cyc(1);
        chk("B_done2", 32'(bus_if.done), 32'h0);
        chk("B_grant2", 32'(bus_if.grant), 32'h0);
        chk("B_tick2", 32'(bus_if.tick), 32'd0);

        // Reset mid-RUN: requester 0, 5 s, reset asserted for edge 23.
        bus_if.dur = {8'd0, 8'd0, 8'd0, 8'd5};
        bus_if.req = 4'b0001;
        cyc(1);
        chk("D_grant0", 32'(bus_if.grant), 32'h1);
        cyc(22);
        chk("D_rem22", 32'(bus_if.remaining), 32'd3);
        reset_n = 1'b0;
        cyc(1);
        chk("D_grant", 32'(bus_if.grant), 32'd0);
        chk("D_done", 32'(bus_if.done), 32'd0);
        chk("D_busy", 32'(bus_if.busy), 32'd0);
        chk("D_rem", 32'(bus_if.remaining), 32'd0);
        chk("D_tick", 32'(bus_if.tick), 32'd0);
        bus_if.req = 4'b0000;
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("D_done_after", 32'(bus_if.done), 32'd0);

        // Contention: all four request together with 1 s, pointer back at 0.
        bus_if.dur = {8'd1, 8'd1, 8'd1, 8'd1};
        bus_if.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            chk($sformatf("C_grant%0d", j), 32'(bus_if.grant), 32'h1 << (j % 4));
            cyc(10);
            chk($sformatf("C_tick%0d", j), 32'(bus_if.tick), 32'd1);
            chk($sformatf("C_nodone%0d", j), 32'(bus_if.done), 32'h0);
            cyc(1);
            chk($sformatf("C_done%0d", j), 32'(bus_if.done), 32'h1 << (j % 4));
            cyc(1);
            chk($sformatf("C_idle%0d", j), 32'(bus_if.grant), 32'h0);
            if (j == 4) bus_if.req = 4'b0000;
        end
        cyc(2);
        chk("C_quiet", 32'(bus_if.grant), 32'h0);

        // Late request: requester 1 raised while requester 0 (2 s) runs.
        bus_if.dur = {8'd0, 8'd0, 8'd1, 8'd2};
        bus_if.req = 4'b0001;
        cyc(1);
        chk("E_grant0", 32'(bus_if.grant), 32'h1);
        cyc(5);
        bus_if.req = 4'b0011;
        cyc(1);
        chk("E_wait6", 32'(bus_if.grant), 32'h1);
        cyc(15);
        chk("E_done21", 32'(bus_if.done), 32'h1);
        bus_if.req = 4'b0010;
        cyc(1);
        chk("E_idle22", 32'(bus_if.grant), 32'h0);
        cyc(1);
        chk("E_grant23", 32'(bus_if.grant), 32'h2);
        cyc(11);
        chk("E_done34", 32'(bus_if.done), 32'h2);
        bus_if.req = 4'b0000;
        cyc(1);
        chk("E_idle35", 32'(bus_if.grant), 32'h0);

        // Requester 3, 4 s, drops req at +15.
        bus_if.dur = {8'd4, 8'd0, 8'd0, 8'd0};
        bus_if.req = 4'b1000;
        cyc(1);
        chk("F_grant0", 32'(bus_if.grant), 32'h8);
        cyc(15);
        chk("F_rem15", 32'(bus_if.remaining), 32'd3);
        bus_if.req = 4'b0000;
        cyc(1);
`ifdef TIMER_ABORT_EN
        chk("F_grant16", 32'(bus_if.grant), 32'h0);
        chk("F_busy16", 32'(bus_if.busy), 32'd0);
        chk("F_rem16", 32'(bus_if.remaining), 32'd0);
`else
        chk("F_grant16", 32'(bus_if.grant), 32'h8);
        chk("F_busy16", 32'(bus_if.busy), 32'd1);
`endif
        for (int t = 17; t <= 43; t++) begin
            cyc(1);
`ifdef TIMER_ABORT_EN
            chk($sformatf("F_done@%0d", t), 32'(bus_if.done), 32'h0);
`else
            chk($sformatf("F_done@%0d", t), 32'(bus_if.done), (t == 41) ? 32'h8 : 32'h0);
`endif
        end
        chk("F_end_grant", 32'(bus_if.grant), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
